// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: programmable step time base plus off/blink/flow/bounce mode FSM.
module led_seq_ctrl #(
  parameter int              LED_NUM = 4,
  parameter int              CNT_W   = 25,
  parameter logic [CNT_W-1:0] CNT_MAX = CNT_W'(24_999_999)
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               mode_next,
  input  logic               pause,
  input  logic               cfg_valid,
  input  logic [CNT_W-1:0]   cfg_period,
  output logic               cfg_ready,
  output logic [LED_NUM-1:0] led_out,
  output logic [1:0]         mode,
  output logic               tick
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLINK  = 2'd1,
    FLOW   = 2'd2,
    BOUNCE = 2'd3
  } mode_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic [LED_NUM-1:0] ONE_HOT0 = LED_NUM'(1);

  mode_t              state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   period_r, period_nxt;
  logic               dir, dir_nxt;
  logic [LED_NUM-1:0] led_nxt, shifted;
  logic               tick_nxt, cfg_ready_nxt;
  logic               term, xfer;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      period_r  <= CNT_MAX;
      dir       <= DIR_LEFT;
      led_out   <= '0;
      tick      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      period_r  <= period_nxt;
      dir       <= dir_nxt;
      led_out   <= led_nxt;
      tick      <= tick_nxt;
      cfg_ready <= cfg_ready_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    period_nxt    = period_r;
    dir_nxt       = dir;
    led_nxt       = led_out;
    shifted       = '0;
    term          = (cnt == period_r) && !pause;
    xfer          = cfg_valid && cfg_ready;
    tick_nxt      = term;

    if (mode_next) begin
      unique case (state)
        IDLE:    state_nxt = BLINK;
        BLINK:   state_nxt = FLOW;
        FLOW:    state_nxt = BOUNCE;
        default: state_nxt = IDLE;
      endcase
    end

    if (!pause) begin
      cnt_nxt = term ? '0 : cnt + CNT_W'(1);
    end
    if (xfer || mode_next) begin
      cnt_nxt = '0;
    end

    // A zero period would make every cycle terminal; the shortest step is two cycles.
    if (xfer) begin
      period_nxt = (cfg_period == '0) ? CNT_W'(1) : cfg_period;
    end

    if (mode_next) begin
      dir_nxt = DIR_LEFT;
      led_nxt = (state_nxt == FLOW || state_nxt == BOUNCE) ? ONE_HOT0 : '0;
    end else if (term) begin
      unique case (state)
        IDLE:  led_nxt = led_out;
        BLINK: led_nxt = ~led_out;
        FLOW:  led_nxt = {led_out[LED_NUM-2:0], led_out[LED_NUM-1]};
        default: begin
          if (dir == DIR_LEFT) begin
            shifted = led_out << 1;
            if (shifted[LED_NUM-1]) dir_nxt = DIR_RIGHT;
          end else begin
            shifted = led_out >> 1;
            if (shifted[0]) dir_nxt = DIR_LEFT;
          end
          led_nxt = shifted;
        end
      endcase
    end

    cfg_ready_nxt = (state_nxt == IDLE);
  end

  assign mode = state;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboarded bench for led_seq_ctrl with a short period (CNT_MAX=4, LED_NUM=4).
module tb_led_seq_ctrl;

  localparam int CNT_W = 25;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mode_next;
  logic             pause;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_period;
  logic             cfg_ready;
  logic [3:0]       led_out;
  logic [1:0]       mode;
  logic             tick;

  typedef struct {
    logic [3:0] led;
    int         gap;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  led_seq_ctrl #(.LED_NUM(4), .CNT_W(CNT_W), .CNT_MAX(25'd4)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .mode_next (mode_next),
    .pause     (pause),
    .cfg_valid (cfg_valid),
    .cfg_period(cfg_period),
    .cfg_ready (cfg_ready),
    .led_out   (led_out),
    .mode      (mode),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (tick) return;
    end
    n = -1;
  endtask

  task automatic push(input logic [3:0] led, input int gap);
    exp_t e;
    e.led = led;
    e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic pulse_mode;
    mode_next = 1'b1;
    @(negedge clk);
    mode_next = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    exp_t e;
    n_tests++;
    if (mode !== 2'd0 || led_out !== 4'b0000 || tick !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: mode=%0d led=%b tick=%b ready=%b, want 0 0000 0 1", mode, led_out, tick, cfg_ready);
    end
    wait_tick(n);
    repeat (3) push(4'b0000, 5);
    while (sb.size() > 0) begin
      wait_tick(n);
      e = sb.pop_front();
      n_tests++;
      if (led_out !== e.led || n !== e.gap) begin
        n_fail++;
        $display("FAIL idle_tick: led=%b gap=%0d, want %b %0d", led_out, n, e.led, e.gap);
      end
    end
  endtask

  task automatic test_blink;
    int n;
    exp_t e;
    pulse_mode();
    n_tests++;
    if (mode !== 2'd1 || led_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL blink_entry: mode=%0d led=%b, want 1 0000", mode, led_out);
    end
    push(4'b1111, 5); push(4'b0000, 5); push(4'b1111, 5);
    while (sb.size() > 0) begin
      wait_tick(n);
      e = sb.pop_front();
      n_tests++;
      if (led_out !== e.led || n !== e.gap) begin
        n_fail++;
        $display("FAIL blink_step: led=%b gap=%0d, want %b %0d", led_out, n, e.led, e.gap);
      end
    end
  endtask

  task automatic test_bounce;
    int n;
    exp_t e;
    pulse_mode();
    pulse_mode();
    n_tests++;
    if (mode !== 2'd3 || led_out !== 4'b0001) begin
      n_fail++;
      $display("FAIL bounce_entry: mode=%0d led=%b, want 3 0001", mode, led_out);
    end
    push(4'b0010, 5); push(4'b0100, 5); push(4'b1000, 5); push(4'b0100, 5);
    push(4'b0010, 5); push(4'b0001, 5); push(4'b0010, 5);
    while (sb.size() > 0) begin
      wait_tick(n);
      e = sb.pop_front();
      n_tests++;
      if (led_out !== e.led || n !== e.gap) begin
        n_fail++;
        $display("FAIL bounce_step: led=%b gap=%0d, want %b %0d", led_out, n, e.led, e.gap);
      end
    end
    pulse_mode();
    n_tests++;
    if (mode !== 2'd0 || led_out !== 4'b0000 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_return: mode=%0d led=%b ready=%b, want 0 0000 1", mode, led_out, cfg_ready);
    end
  endtask

  task automatic test_config;
    int n;
    exp_t e;
    logic rdy;
    cfg_valid = 1'b1;
    cfg_period = 25'd9;
    rdy = cfg_ready;
    @(negedge clk);
    cfg_valid = 1'b0;
    n_tests++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_accept: ready=%b, want 1", rdy);
    end
    push(4'b0000, 10); push(4'b0000, 10);
    while (sb.size() > 0) begin
      wait_tick(n);
      e = sb.pop_front();
      n_tests++;
      if (led_out !== e.led || n !== e.gap) begin
        n_fail++;
        $display("FAIL cfg_period9: led=%b gap=%0d, want %b %0d", led_out, n, e.led, e.gap);
      end
    end
    cfg_valid = 1'b1;
    cfg_period = 25'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (3) push(4'b0000, 2);
    while (sb.size() > 0) begin
      wait_tick(n);
      e = sb.pop_front();
      n_tests++;
      if (led_out !== e.led || n !== e.gap) begin
        n_fail++;
        $display("FAIL cfg_period0: led=%b gap=%0d, want %b %0d", led_out, n, e.led, e.gap);
      end
    end
    cfg_valid = 1'b1;
    cfg_period = 25'd4;
    @(negedge clk);
    cfg_valid = 1'b0;
    pulse_mode();
    pulse_mode();
    cfg_valid = 1'b1;
    cfg_period = 25'd20;
    n_tests++;
    if (mode !== 2'd2 || led_out !== 4'b0001 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flow_entry: mode=%0d led=%b ready=%b, want 2 0001 0", mode, led_out, cfg_ready);
    end
    push(4'b0010, 5); push(4'b0100, 5); push(4'b1000, 5); push(4'b0001, 5);
    while (sb.size() > 0) begin
      wait_tick(n);
      e = sb.pop_front();
      n_tests++;
      if (led_out !== e.led || n !== e.gap || cfg_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL cfg_stall: led=%b gap=%0d ready=%b, want %b %0d 0", led_out, n, cfg_ready, e.led, e.gap);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_pause;
    int n;
    int bad;
    exp_t e;
    wait_tick(n);
    n_tests++;
    if (led_out !== 4'b0010 || n !== 5) begin
      n_fail++;
      $display("FAIL pause_pre: led=%b gap=%0d, want 0010 5", led_out, n);
    end
    repeat (2) @(negedge clk);
    pause = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tick !== 1'b0 || led_out !== 4'b0010) bad++;
    end
    pause = 1'b0;
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL pause_hold: %0d bad cycles, want 0", bad);
    end
    push(4'b0100, 3);
    while (sb.size() > 0) begin
      wait_tick(n);
      e = sb.pop_front();
      n_tests++;
      if (led_out !== e.led || n !== e.gap) begin
        n_fail++;
        $display("FAIL pause_resume: led=%b gap=%0d, want %b %0d", led_out, n, e.led, e.gap);
      end
    end
  endtask

  task automatic test_simultaneous;
    int n;
    exp_t e;
    pulse_mode();
    pulse_mode();
    pulse_mode();
    n_tests++;
    if (mode !== 2'd1 || led_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL blink_reentry: mode=%0d led=%b, want 1 0000", mode, led_out);
    end
    repeat (4) @(negedge clk);
    pulse_mode();
    n_tests++;
    if (mode !== 2'd2 || led_out !== 4'b0001 || tick !== 1'b1) begin
      n_fail++;
      $display("FAIL term_collision: mode=%0d led=%b tick=%b, want 2 0001 1", mode, led_out, tick);
    end
    push(4'b0010, 5);
    while (sb.size() > 0) begin
      wait_tick(n);
      e = sb.pop_front();
      n_tests++;
      if (led_out !== e.led || n !== e.gap) begin
        n_fail++;
        $display("FAIL collision_restart: led=%b gap=%0d, want %b %0d", led_out, n, e.led, e.gap);
      end
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (mode !== 2'd0 || led_out !== 4'b0000 || tick !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: mode=%0d led=%b tick=%b ready=%b, want 0 0000 0 1", mode, led_out, tick, cfg_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_period = 25'd6;
    mode_next = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    mode_next = 1'b0;
    n_tests++;
    if (mode !== 2'd1 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_and_mode: mode=%0d ready=%b, want 1 0", mode, cfg_ready);
    end
    push(4'b1111, 7);
    while (sb.size() > 0) begin
      wait_tick(n);
      e = sb.pop_front();
      n_tests++;
      if (led_out !== e.led || n !== e.gap) begin
        n_fail++;
        $display("FAIL cfg_and_mode_step: led=%b gap=%0d, want %b %0d", led_out, n, e.led, e.gap);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mode_next = 1'b0;
    pause = 1'b0;
    cfg_valid = 1'b0;
    cfg_period = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_blink();
    test_bounce();
    test_config();
    test_pause();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
